// File: rtl/xy_router_input_port_if.sv
// Flit stream, route request/grant and output stream of one router input port.
interface xy_router_input_port_if #(
  parameter int unsigned DATA_WIDTH = 40
);
  logic [DATA_WIDTH-1:0] in_tdata;
  logic                  in_tvalid;
  logic                  in_tlast;
  logic                  in_tready;
  logic [4:0]            route_req;
  logic [4:0]            grant;
  logic [DATA_WIDTH-1:0] out_tdata;
  logic                  out_tvalid;
  logic                  out_tlast;
  logic                  out_tready;

  // Upstream source / arbiter / downstream sink side
  modport master (
    output in_tdata, in_tvalid, in_tlast, grant, out_tready,
    input  in_tready, route_req, out_tdata, out_tvalid, out_tlast
  );

  // Input port side
  modport slave (
    input  in_tdata, in_tvalid, in_tlast, grant, out_tready,
    output in_tready, route_req, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/xy_router_input_port.sv
// Mesh router input port: flit FIFO, XY route decode, per-packet request and stream-out.
module xy_router_input_port #(
  parameter int unsigned DATA_WIDTH    = 40,
  parameter int unsigned ROUTER_X      = 0,
  parameter int unsigned ROUTER_Y      = 0,
  parameter int unsigned MAX_ROUTERS_X = 3,
  parameter int unsigned MAX_ROUTERS_Y = 3,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned X_W = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
  parameter int unsigned Y_W = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  xy_router_input_port_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [15:0]                   drop_cnt
);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  localparam logic [4:0] PORT_HOME  = 5'b00001;
  localparam logic [4:0] PORT_NORTH = 5'b00010;
  localparam logic [4:0] PORT_EAST  = 5'b00100;
  localparam logic [4:0] PORT_SOUTH = 5'b01000;
  localparam logic [4:0] PORT_WEST  = 5'b10000;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} state_t;

  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  state_t                state_q, state_d;
  logic [4:0]            req_q, req_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic                  empty, full, push, pop, drop_hit, out_valid_c;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic [Y_W-1:0]        dest_y;
  logic [X_W-1:0]        dest_x;
  logic [31:0]           dx, dy;
  logic [4:0]            dec_route;
  logic                  dec_drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign push      = bus.in_tvalid & ~full;
  assign head_data = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign head_last = mem_q[rd_ptr_q][DATA_WIDTH];
  assign dest_y    = head_data[DATA_WIDTH-1 -: Y_W];
  assign dest_x    = head_data[DATA_WIDTH-1-Y_W -: X_W];
  assign dx        = 32'(dest_x);
  assign dy        = 32'(dest_y);

  assign bus.in_tready  = ~full;
  assign bus.route_req  = req_q;
  assign bus.out_tvalid = out_valid_c;
  assign bus.out_tdata  = head_data;
  assign bus.out_tlast  = head_last;
  assign occupancy      = count_q;
  assign drop_cnt       = drop_cnt_q;

  // XY decode of the head flit, X dimension first; out-of-mesh destinations drop
  always_comb begin
    dec_route = PORT_HOME;
    dec_drop  = 1'b0;
    if (dx >= MAX_ROUTERS_X || dy >= MAX_ROUTERS_Y) begin
      dec_route = '0;
      dec_drop  = 1'b1;
    end else if (dx > ROUTER_X) begin
      dec_route = PORT_EAST;
    end else if (dx < ROUTER_X) begin
      dec_route = PORT_WEST;
    end else if (dy > ROUTER_Y) begin
      dec_route = PORT_SOUTH;
    end else if (dy < ROUTER_Y) begin
      dec_route = PORT_NORTH;
    end
  end

  // Packet FSM: next state, latched request, FIFO pop and drop accounting
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    pop         = 1'b0;
    drop_hit    = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (dec_drop) begin
            state_d = DROP;
            req_d   = '0;
          end else begin
            state_d = REQ;
            req_d   = dec_route;
          end
        end
      end
      REQ: begin
        if ((bus.grant & req_q) != '0) state_d = XFER;
      end
      XFER: begin
        out_valid_c = ~empty;
        if (out_valid_c && bus.out_tready) begin
          pop = 1'b1;
          if (head_last) begin
            state_d = IDLE;
            req_d   = '0;
          end
        end
      end
      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_last) begin
            state_d  = IDLE;
            drop_hit = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
      end
    endcase
  end

  // Fill level and saturating drop counter
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    drop_cnt_d = drop_cnt_q;
    if (drop_hit && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Control state; reset flushes the FIFO and abandons any packet in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Flit storage with tlast kept alongside the data
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_tlast, bus.in_tdata};
  end
endmodule

// File: tb/tb_xy_router_input_port.sv
// Directed bench for xy_router_input_port at router (1,1) in a 3x3 mesh, scoreboard-checked.
module tb_xy_router_input_port;
  localparam int unsigned DW = 40;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [4:0]    r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  occupancy;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int exp_drop = 0;
  exp_t sb[$];

  // Single-flit route table: dest x, dest y, expected request (0 = dropped)
  int         tx [8] = '{0, 1, 1, 1, 0, 2, 1, 3};
  int         ty [8] = '{1, 0, 2, 1, 2, 2, 3, 0};
  logic [4:0] tr [8] = '{5'b10000, 5'b00010, 5'b01000, 5'b00001,
                         5'b10000, 5'b00100, 5'b00000, 5'b00000};

  xy_router_input_port_if #(.DATA_WIDTH(DW)) bus();

  xy_router_input_port #(
    .DATA_WIDTH(DW), .ROUTER_X(1), .ROUTER_Y(1),
    .MAX_ROUTERS_X(3), .MAX_ROUTERS_Y(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] hdr(input int x, input int y, input logic [31:0] pl);
    logic [DW-1:0] f;
    f = '0;
    f[39:38] = 2'(y);
    f[37:36] = 2'(x);
    f[31:0]  = pl;
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one flit and hold it until accepted (bounded)
  task automatic send(input logic [DW-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    bus.in_tdata  = d;
    bus.in_tlast  = l;
    bus.in_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_tready) done = 1'b1;
      tick();
    end
    bus.in_tvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_tready stayed 0, expected 1");
    end
  endtask

  // Wait for all expected flits to leave and the port to go idle (bounded)
  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (sb.size() == 0 && occupancy == 3'd0 && bus.route_req == 5'd0) done = 1'b1;
      else tick();
    end
    chk(name, 64'(done), 64'(1));
  endtask

  // Monitor: every output handshake must match the next expected flit and its route
  always @(negedge clk) begin
    if (!rst && bus.out_tvalid && bus.out_tready) begin
      hs_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit: got %0h, expected no output", bus.out_tdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_tdata", 64'(bus.out_tdata), 64'(e.d));
        chk("out_tlast", 64'(bus.out_tlast), 64'(e.l));
        chk("route_req_on_xfer", 64'(bus.route_req), 64'(e.r));
      end
    end
  end

  initial begin
    bit bad;
    logic [1:0] pat [4];
    rst = 1'b1;
    bus.in_tdata = '0; bus.in_tvalid = 1'b0; bus.in_tlast = 1'b0;
    bus.grant = '0; bus.out_tready = 1'b1;
    tick(); tick();
    chk("rst_route_req", 64'(bus.route_req), 64'(0));
    chk("rst_out_tvalid", 64'(bus.out_tvalid), 64'(0));
    chk("rst_in_tready", 64'(bus.in_tready), 64'(1));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    rst = 1'b0;
    tick();

    // Single flit to (2,0): EAST, latency to request and to first valid
    sb.push_back('{hdr(2, 0, 32'hA1), 1'b1, 5'b00100});
    send(hdr(2, 0, 32'hA1), 1'b1);
    chk("t1_req_cycle1", 64'(bus.route_req), 64'(0));
    tick();
    chk("t1_req_cycle2", 64'(bus.route_req), 64'(5'b00100));
    tick();
    bus.grant = 5'b00100;
    chk("t1_valid_cycle3", 64'(bus.out_tvalid), 64'(0));
    tick();
    chk("t1_valid_cycle4", 64'(bus.out_tvalid), 64'(1));
    tick();
    chk("t1_idle_req", 64'(bus.route_req), 64'(0));
    chk("t1_idle_valid", 64'(bus.out_tvalid), 64'(0));
    bus.grant = '0;
    drain("t1_drain");

    // Three-flit HOME packet with out_tready pattern 1,0,1,1
    bus.grant = 5'b00001;
    hs_count = 0;
    for (int k = 0; k < 3; k++) begin
      logic [DW-1:0] d;
      d = (k == 0) ? hdr(1, 1, 32'hB0) : DW'(64'hC0DE_0000 + 64'(k));
      sb.push_back('{d, (k == 2), 5'b00001});
      send(d, (k == 2));
    end
    bad = 1'b1;
    for (int i = 0; i < 20 && bad; i++) begin
      if (bus.out_tvalid) bad = 1'b0;
      else tick();
    end
    chk("t2_valid_seen", 64'(bad), 64'(0));
    pat = '{2'd1, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) begin
      bus.out_tready = pat[i][0];
      tick();
    end
    bus.out_tready = 1'b1;
    chk("t2_req_after_last", 64'(bus.route_req), 64'(0));
    chk("t2_handshakes", 64'(hs_count), 64'(3));
    bus.grant = '0;
    drain("t2_drain");

    // Out-of-mesh destination (3,0): two flits dropped, never requested
    send(hdr(3, 0, 32'hD0), 1'b0);
    send(DW'(64'hD1), 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.route_req != 5'd0 || bus.out_tvalid) bad = 1'b1;
      tick();
    end
    exp_drop++;
    chk("t3_no_request", 64'(bad), 64'(0));
    chk("t3_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("t3_occupancy", 64'(occupancy), 64'(0));
    bus.grant = 5'b10000;
    sb.push_back('{hdr(0, 1, 32'hE0), 1'b0, 5'b10000});
    sb.push_back('{DW'(64'hE1), 1'b1, 5'b10000});
    send(hdr(0, 1, 32'hE0), 1'b0);
    send(DW'(64'hE1), 1'b1);
    drain("t3_next_drain");
    bus.grant = '0;

    // Route table of single-flit packets, including out-of-range y and x
    for (int k = 0; k < 8; k++) begin
      bus.grant = tr[k];
      if (tr[k] != 5'd0) sb.push_back('{hdr(tx[k], ty[k], 32'(k)), 1'b1, tr[k]});
      else exp_drop++;
      send(hdr(tx[k], ty[k], 32'(k)), 1'b1);
      repeat (6) tick();
      chk("tbl_occupancy", 64'(occupancy), 64'(0));
      chk("tbl_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    end
    bus.grant = '0;
    drain("tbl_drain");

    // FIFO full backpressure with grant withheld, then drain
    for (int k = 0; k < 6; k++)
      sb.push_back('{(k == 0) ? hdr(2, 1, 32'hF0) : DW'(64'hF0 + 64'(k)), (k == 5), 5'b00100});
    send(hdr(2, 1, 32'hF0), 1'b0);
    for (int k = 1; k < 4; k++) send(DW'(64'hF0 + 64'(k)), 1'b0);
    bus.in_tdata = DW'(64'hF4); bus.in_tlast = 1'b0; bus.in_tvalid = 1'b1;
    chk("t4_full_ready", 64'(bus.in_tready), 64'(0));
    chk("t4_full_occ", 64'(occupancy), 64'(4));
    tick(); tick();
    chk("t4_hold_occ", 64'(occupancy), 64'(4));
    chk("t4_hold_req", 64'(bus.route_req), 64'(5'b00100));
    bus.grant = 5'b00100;
    tick();
    chk("t4_ready_first_pop", 64'(bus.in_tready), 64'(0));
    tick();
    chk("t4_ready_after_pop", 64'(bus.in_tready), 64'(1));
    send(DW'(64'hF4), 1'b0);
    send(DW'(64'hF5), 1'b1);
    drain("t4_drain");
    bus.grant = '0;

    // Non-matching grant bit is ignored until SOUTH is granted
    bus.grant = 5'b00010;
    sb.push_back('{hdr(1, 2, 32'h5A), 1'b1, 5'b01000});
    send(hdr(1, 2, 32'h5A), 1'b1);
    tick();
    chk("t6_req_south", 64'(bus.route_req), 64'(5'b01000));
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_tvalid || bus.route_req != 5'b01000) bad = 1'b1;
      tick();
    end
    chk("t6_wait_in_req", 64'(bad), 64'(0));
    bus.grant = 5'b01000;
    tick();
    chk("t6_valid_after_grant", 64'(bus.out_tvalid), 64'(1));
    drain("t6_drain");
    bus.grant = '0;

    // Reset mid-transfer with two flits buffered
    bus.grant = 5'b00100;
    bus.out_tready = 1'b0;
    send(hdr(2, 0, 32'h77), 1'b0);
    send(DW'(64'h78), 1'b0);
    bad = 1'b1;
    for (int i = 0; i < 20 && bad; i++) begin
      if (bus.out_tvalid) bad = 1'b0;
      else tick();
    end
    chk("t5_in_xfer", 64'(bad), 64'(0));
    chk("t5_occ_before", 64'(occupancy), 64'(2));
    rst = 1'b1;
    #1;
    chk("t5_rst_req", 64'(bus.route_req), 64'(0));
    chk("t5_rst_valid", 64'(bus.out_tvalid), 64'(0));
    chk("t5_rst_occ", 64'(occupancy), 64'(0));
    chk("t5_rst_ready", 64'(bus.in_tready), 64'(1));
    chk("t5_rst_drop", 64'(drop_cnt), 64'(0));
    tick();
    rst = 1'b0;
    bus.out_tready = 1'b1;
    bus.grant = 5'b00001;
    tick();
    sb.push_back('{hdr(1, 1, 32'h99), 1'b1, 5'b00001});
    send(hdr(1, 1, 32'h99), 1'b1);
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xy_router_input_port.md
Name: xy_router_input_port

Overview:
- Input-port stage of the mesh router, one instance per router direction (HOME, NORTH, EAST, SOUTH, WEST).
- The HOME instance consumes the 40-bit flit stream produced by the AXI-to-AXIS bridge.
- Buffers flits in a FIFO and decodes the XY destination from each header flit.
- Requests one output port per packet, then streams the packet to the granted output until TLAST; malformed destinations are discarded and counted.

Parameters:
- DATA_WIDTH, 40, flit width.
- ROUTER_X, 0, this router's column.
- ROUTER_Y, 0, this router's row.
- MAX_ROUTERS_X, 3, mesh columns.
- MAX_ROUTERS_Y, 3, mesh rows.
- FIFO_DEPTH, 4, flit buffer entries; power of two, at least 2.
- X_W, $clog2(MAX_ROUTERS_X) (minimum 1), destination-X field width.
- Y_W, $clog2(MAX_ROUTERS_Y) (minimum 1), destination-Y field width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_tdata  in  DATA_WIDTH  incoming flit.
- in_tvalid  in  1  incoming flit valid.
- in_tlast  in  1  last flit of packet.
- in_tready  out  1  = !full.
- route_req  out  5  one-hot output request; bit 0 HOME, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST.
- grant  in  5  one-hot grant from the output arbiters.
- out_tdata  out  DATA_WIDTH  head flit.
- out_tvalid  out  1  head flit valid toward the granted output.
- out_tlast  out  1  head flit last.
- out_tready  in  1  ready of the granted output.
- occupancy  out  $clog2(FIFO_DEPTH)+1  current FIFO fill.
- drop_cnt  out  16  packets discarded; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, synchronous release): FIFO empty, state IDLE, route_req=0, out_tvalid=0, in_tready=1, occupancy=0, drop_cnt=0.
- Header flit fields: dest_y = TDATA[DATA_WIDTH-1 -: Y_W]; dest_x = the next X_W bits below dest_y. A header is any flit at the FIFO head in IDLE.
- FIFO:
  - Push on in_tvalid & in_tready.
  - Pop on out_tvalid & out_tready, or on every head flit in DROP.
  - Full means no push, even if a pop occurs the same cycle (no bypass).
  - Simultaneous push and pop with 0 < occupancy < FIFO_DEPTH leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pushed flit is visible at the head the next cycle.
- Route decode (registered in IDLE when not empty), X first:
  - dest_x > ROUTER_X → EAST; dest_x < ROUTER_X → WEST.
  - Otherwise dest_y > ROUTER_Y → SOUTH; dest_y < ROUTER_Y → NORTH.
  - Otherwise HOME.
  - dest_x ≥ MAX_ROUTERS_X or dest_y ≥ MAX_ROUTERS_Y → DROP.
- State machine:
  - IDLE: not empty → REQ with latched route, or DROP.
  - REQ: route_req = latched one-hot. When (grant & route_req) ≠ 0 → XFER next cycle. Grant bits outside route_req are ignored.
  - XFER: route_req held; out_tvalid = !empty. Each handshake pops one flit. A handshake with out_tlast=1 → IDLE; route_req deasserts in the following cycle.
  - DROP: out_tvalid=0, route_req=0. Pops one flit per cycle while not empty. Popping the tlast flit increments drop_cnt (saturating) → IDLE.
- FIFO empty mid-packet in XFER or DROP: wait with out_tvalid=0; the route stays locked.
- Latency: input handshake at cycle 0 → route_req at cycle 2. Grant seen at cycle n → first out_tvalid at n+1. Back-to-back packets incur two idle cycles between the last and the next header handshake.
- Single-flit packet (header with tlast=1) is a complete packet.
- out_tdata and out_tlast are driven from the FIFO head combinationally; they are don't-care when out_tvalid=0.
- grant dropping during XFER is an arbiter protocol violation; the route is not re-evaluated.
- rst mid-packet flushes the FIFO and abandons the packet. drop_cnt is cleared.

Test Plan:
- ROUTER (1,1), 3x3 mesh; single-flit header with dest (x=2,y=0), grant=5'b00100 one cycle after route_req → route_req=5'b00100 at cycle 2; out_tvalid at cycle 4; then IDLE.
- ROUTER (1,1); dest (1,1), 3-flit packet, out_tready toggling 1,0,1,1 → route_req=HOME; exactly 3 handshakes, payload order preserved; route_req low the cycle after the tlast handshake.
- dest (3,0) on a 3x3 mesh, 2-flit packet → no route_req; 2 flits popped; drop_cnt=1; next valid packet routed normally.
- FIFO_DEPTH=4, grant withheld, 6 flits offered → in_tready low after 4 pushes; occupancy=4. Grant issued → one flit per cycle drains, and in_tready rises the cycle after the first pop.
- Assert rst mid-XFER with 2 flits buffered → same-cycle route_req=0, out_tvalid=0, occupancy=0, in_tready=1.
- grant=5'b00010 while route_req=5'b01000 → stays in REQ, out_tvalid=0, until the SOUTH grant bit is set.
